// File: rtl/fft_controller_if.sv
// Control/handshake bundle between the FFT sequencer and its environment:
// command inputs, the load and scan valid/ready streams, and the RAM-mux and
// address_generator control outputs.
interface fft_controller_if #(
    parameter int LOG2N = 10
);
    logic                 start;
    logic                 abort;
    logic                 in_valid;
    logic                 in_ready;
    logic                 out_ready;
    logic                 out_valid;
    logic                 externalLoad;
    logic                 scan;
    logic                 load;
    logic [LOG2N-1:0]     externalIndexA;
    logic [4:0]           stageCount;
    logic [LOG2N-2:0]     cycleCount;
    logic                 busy;
    logic                 done;

    // Controller side
    modport master (
        input  start, abort, in_valid, out_ready,
        output in_ready, out_valid, externalLoad, scan, load,
               externalIndexA, stageCount, cycleCount, busy, done
    );

    // Environment side (sample source, result sink, datapath muxes)
    modport slave (
        output start, abort, in_valid, out_ready,
        input  in_ready, out_valid, externalLoad, scan, load,
               externalIndexA, stageCount, cycleCount, busy, done
    );
endinterface

// File: rtl/fft_controller.sv
// Sequencer for the radix-2 FFT datapath. Loads N samples into the RAM,
// steps address_generator through LOG2N stages of N/2 butterflies, then
// scans the N results out. Drives control and indices only; no sample data.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start, all control outputs low
// S_LOAD    | accepting samples on the input stream, idx = RAM address
// S_COMPUTE | one butterfly write per cycle, stage/cycle counters running
// S_SCAN    | presenting results on the output stream, idx = RAM address
// S_DONE    | one-cycle completion pulse, then back to idle
module fft_controller #(
    parameter int N     = 1024,
    parameter int LOG2N = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    fft_controller_if.master   bus
);

    localparam int IDX_W = LOG2N;
    localparam int CYC_W = LOG2N - 1;
    localparam int STG_W = 5;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(N / 2 - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(LOG2N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_SCAN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [STG_W-1:0]   stage_q, stage_d;
    logic [CYC_W-1:0]   cycle_q, cycle_d;

    // State and counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            stage_q <= '0;
            cycle_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            cycle_q <= cycle_d;
        end
    end

    // Next-state and counter update; abort overrides every transition
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        cycle_d = cycle_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                if (bus.in_valid) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_COMPUTE: begin
                if (cycle_q == CYC_LAST) begin
                    cycle_d = '0;
                    if (stage_q == STG_LAST) begin
                        stage_d = '0;
                        state_d = S_SCAN;
                    end else begin
                        stage_d = stage_q + 1'b1;
                    end
                end else begin
                    cycle_d = cycle_q + 1'b1;
                end
            end
            S_SCAN: begin
                if (bus.out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
            stage_d = '0;
            cycle_d = '0;
        end
    end

    // Output decode from registered state; only load in S_LOAD follows in_valid
    always_comb begin
        bus.in_ready       = 1'b0;
        bus.out_valid      = 1'b0;
        bus.externalLoad   = 1'b0;
        bus.scan           = 1'b0;
        bus.load           = 1'b0;
        bus.busy           = (state_q != S_IDLE);
        bus.done           = 1'b0;
        bus.externalIndexA = idx_q;
        bus.stageCount     = stage_q;
        bus.cycleCount     = cycle_q;

        unique case (state_q)
            S_LOAD: begin
                bus.in_ready     = 1'b1;
                bus.externalLoad = 1'b1;
                bus.load         = bus.in_valid;
            end
            S_COMPUTE: begin
                bus.load = 1'b1;
            end
            S_SCAN: begin
                bus.scan      = 1'b1;
                bus.out_valid = 1'b1;
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_fft_controller.sv
// Directed bench for fft_controller: reset state, unstalled and stalled
// transforms, abort during load, start ignored while busy, async reset
// in the middle of the compute phase.
module tb_fft_controller;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;

    fft_controller_if #(.LOG2N(10)) bus ();

    fft_controller #(.N(1024), .LOG2N(10)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;
    int errs   = 0;
    int busy_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {1'b0, bus.in_ready, bus.out_valid, bus.externalLoad, bus.scan, bus.load,
                bus.busy, bus.done, bus.externalIndexA, bus.stageCount, bus.cycleCount};
    endfunction

    task automatic do_start();
        @(negedge clk_i);
        bus.start = 1'b1;
        #1;
        chk("idle_before_start", 32'(bus.busy), 32'd0);
        busy_cnt = 0;
        errs = 0;
    endtask

    // Feed samples; optional in_valid stall, optional abort at abort_idx
    task automatic do_load(input int stall_idx, input int stall_len, input int abort_idx);
        int idx = 0;
        int stalled = 0;
        int writes = 0;
        int guard = 0;
        bit aborted = 1'b0;
        while (idx < 1024 && guard < 4000 && !aborted) begin
            @(negedge clk_i);
            bus.start = 1'b0;
            bus.in_valid = !(idx == stall_idx && stalled < stall_len);
            if (!bus.in_valid) stalled++;
            if (idx == abort_idx) begin
                bus.abort = 1'b1;
                aborted = 1'b1;
            end
            #1;
            guard++;
            if (bus.busy) busy_cnt++;
            if (bus.in_ready !== 1'b1 || bus.externalLoad !== 1'b1 || bus.scan !== 1'b0 ||
                bus.out_valid !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
                bus.externalIndexA !== 10'(idx) || bus.load !== bus.in_valid)
                errs++;
            if (bus.load === 1'b1) writes++;
            if (bus.in_valid && !aborted) idx++;
        end
        chk("load_errs", 32'(errs), 32'd0);
        errs = 0;
        if (abort_idx < 0) begin
            chk("load_beats", 32'(idx), 32'd1024);
            chk("load_writes", 32'(writes), 32'd1024);
        end else begin
            chk("abort_at_idx", 32'(idx), 32'(abort_idx));
        end
    endtask

    // Walk n compute cycles against the expected stage/cycle sequence
    task automatic do_compute(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_i);
            bus.in_valid = 1'b0;
            #1;
            if (bus.busy) busy_cnt++;
            if (bus.load !== 1'b1 || bus.externalLoad !== 1'b0 || bus.scan !== 1'b0 ||
                bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b1 ||
                bus.done !== 1'b0 || bus.stageCount !== 5'(k / 512) ||
                bus.cycleCount !== 9'(k % 512))
                errs++;
        end
        chk("compute_errs", 32'(errs), 32'd0);
        errs = 0;
    endtask

    // Drain results; optional out_ready stall and a start pulse at poke_idx
    task automatic do_scan(input int stall_idx, input int stall_len, input int poke_idx);
        int idx = 0;
        int stalled = 0;
        int guard = 0;
        while (idx < 1024 && guard < 4000) begin
            @(negedge clk_i);
            bus.out_ready = !(idx == stall_idx && stalled < stall_len);
            if (!bus.out_ready) stalled++;
            bus.start = (idx == poke_idx);
            #1;
            guard++;
            if (bus.busy) busy_cnt++;
            if (bus.out_valid !== 1'b1 || bus.scan !== 1'b1 || bus.load !== 1'b0 ||
                bus.externalLoad !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1 ||
                bus.done !== 1'b0 || bus.externalIndexA !== 10'(idx) ||
                bus.stageCount !== 5'd0 || bus.cycleCount !== 9'd0)
                errs++;
            if (bus.out_ready) idx++;
        end
        chk("scan_errs", 32'(errs), 32'd0);
        errs = 0;
        chk("scan_beats", 32'(idx), 32'd1024);
    endtask

    task automatic do_done(input int exp_total);
        @(negedge clk_i);
        bus.out_ready = 1'b0;
        bus.start = 1'b0;
        #1;
        if (bus.busy) busy_cnt++;
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_busy", 32'(bus.busy), 32'd1);
        chk("done_no_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk_i);
        #1;
        chk("after_done", {30'd0, bus.done, bus.busy}, 32'd0);
        chk("after_done_ready", 32'(bus.in_ready), 32'd0);
        chk("total_cycles", 32'(busy_cnt + 1), 32'(exp_total));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;

        #1;
        chk("reset_outs", all_outs(), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        chk("idle_outs", all_outs(), 32'd0);

        // Unstalled transform
        do_start();
        do_load(-1, 0, -1);
        do_compute(5120);
        do_scan(-1, 0, -1);
        do_done(7170);

        // Stalled transform with a start pulse during scan
        do_start();
        do_load(300, 7, -1);
        do_compute(5120);
        do_scan(1000, 5, 10);
        do_done(7170 + 7 + 5);

        // Abort during load
        do_start();
        do_load(-1, 0, 512);
        @(negedge clk_i);
        bus.abort = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("abort_idle", 32'(bus.busy), 32'd0);
        chk("abort_idx_clr", 32'(bus.externalIndexA), 32'd0);
        // start and abort together: abort wins
        @(negedge clk_i);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk_i);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        #1;
        chk("start_abort_idle", all_outs(), 32'd0);
        // Fresh transform after abort starts at idx 0
        do_start();
        do_load(-1, 0, -1);
        do_compute(5120);
        do_scan(-1, 0, -1);
        do_done(7170);

        // Async reset at stage 4, cycle 100
        do_start();
        do_load(-1, 0, -1);
        do_compute(4 * 512 + 100);
        @(negedge clk_i);
        #1;
        chk("pre_rst_stage", 32'(bus.stageCount), 32'd4);
        chk("pre_rst_cycle", 32'(bus.cycleCount), 32'd100);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_outs", all_outs(), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        chk("post_rst_idle", all_outs(), 32'd0);
        @(negedge clk_i);
        #1;
        chk("post_rst_stays_idle", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
